// File: rtl/fc_pkg.sv
// Shared FC-layer definitions: default widths, FSM state encoding, signed clip bounds.
// No logic; latency and backpressure are owned by the modules importing this package.
package fc_pkg;

    localparam int A_BW_DEF   = 8;
    localparam int OUT_BW_DEF = 16;
    localparam int C_BW_DEF   = OUT_BW_DEF - 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_ISSUE = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_FETCH = ST_FETCH,
        S_LOAD  = ST_LOAD,
        S_ISSUE = ST_ISSUE,
        S_WAIT  = ST_WAIT,
        S_DONE  = ST_DONE
    } state_t;

    function automatic int sat_max(input int c_bw);
        return (1 << (c_bw - 1)) - 1;
    endfunction

    function automatic int sat_min(input int c_bw);
        return -(1 << (c_bw - 1));
    endfunction

endpackage

// File: rtl/fc_mac_sequencer_if.sv
// Operand-buffer read port plus MAC en/done request channel, seen from the sequencer (master).
// Buffer data returns one cycle after rd_en; the MAC answers each mac_en with exactly one mac_done.
interface fc_mac_sequencer_if
    import fc_pkg::*;
#(
    parameter int A_BITWIDTH    = A_BW_DEF,
    parameter int OUT_BITWIDTH  = OUT_BW_DEF,
    parameter int C_BITWIDTH    = C_BW_DEF,
    parameter int ADDR_BITWIDTH = 4
);

    logic                            rd_en;
    logic        [ADDR_BITWIDTH-1:0] rd_addr;
    logic signed [A_BITWIDTH-1:0]    rd_data_a;
    logic signed [A_BITWIDTH-1:0]    rd_data_b;

    logic                            mac_en;
    logic signed [A_BITWIDTH-1:0]    mac_data_a;
    logic signed [A_BITWIDTH-1:0]    mac_data_b;
    logic signed [C_BITWIDTH-1:0]    mac_data_c;
    logic                            mac_done;
    logic signed [OUT_BITWIDTH-1:0]  mac_mout;

    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data_a,
        input  rd_data_b,
        output mac_en,
        output mac_data_a,
        output mac_data_b,
        output mac_data_c,
        input  mac_done,
        input  mac_mout
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data_a,
        output rd_data_b,
        input  mac_en,
        input  mac_data_a,
        input  mac_data_b,
        input  mac_data_c,
        output mac_done,
        output mac_mout
    );

endinterface

// File: rtl/fc_sat_clip.sv
// Signed IN_W -> OUT_W saturator with a clip flag, shared by FC output stages.
// Purely combinational (zero latency); no handshake.
module fc_sat_clip
    import fc_pkg::*;
#(
    parameter int IN_W  = OUT_BW_DEF,
    parameter int OUT_W = C_BW_DEF
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    clip
);

    // Bounds are widened to IN_W so the comparisons stay signed and same-width.
    localparam logic signed [IN_W-1:0]  HI_IN  = IN_W'(sat_max(OUT_W));
    localparam logic signed [IN_W-1:0]  LO_IN  = IN_W'(sat_min(OUT_W));
    localparam logic signed [OUT_W-1:0] HI_OUT = OUT_W'(sat_max(OUT_W));
    localparam logic signed [OUT_W-1:0] LO_OUT = OUT_W'(sat_min(OUT_W));

    always_comb begin
        clip = 1'b0;
        dout = din[OUT_W-1:0];
        if (din > HI_IN) begin
            dout = HI_OUT;
            clip = 1'b1;
        end else if (din < LO_IN) begin
            dout = LO_OUT;
            clip = 1'b1;
        end
    end

endmodule

// File: rtl/fc_mac_sequencer.sv
// Walks VEC_LEN operand pairs through the MAC, feeding each clipped partial sum back as the next addend.
// 7 cycles per element plus 2 (result_valid at 7*VEC_LEN+1); waits on mac_done, start ignored while busy.
module fc_mac_sequencer
    import fc_pkg::*;
#(
    parameter int A_BITWIDTH    = A_BW_DEF,
    parameter int OUT_BITWIDTH  = OUT_BW_DEF,
    parameter int C_BITWIDTH    = OUT_BITWIDTH - 1,
    parameter int VEC_LEN       = 16,
    parameter int ADDR_BITWIDTH = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start,
    input  logic signed [C_BITWIDTH-1:0]   bias,
    output logic                           busy,
    output logic                           result_valid,
    output logic signed [OUT_BITWIDTH-1:0] result,
    output logic                           sat,
    fc_mac_sequencer_if.master             bus
);

    localparam logic [ADDR_BITWIDTH-1:0] LAST_IDX = ADDR_BITWIDTH'(VEC_LEN - 1);

    state_t                         state_q, state_d;
    logic        [ADDR_BITWIDTH-1:0] idx_q, idx_d;
    logic signed [C_BITWIDTH-1:0]    acc_q, acc_d;
    logic                            sat_q, sat_d;
    logic signed [OUT_BITWIDTH-1:0]  result_q, result_d;
    logic                            rv_q, rv_d;
    logic                            busy_q, busy_d;
    logic                            rd_en_q, rd_en_d;
    logic        [ADDR_BITWIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                            mac_en_q, mac_en_d;
    logic signed [A_BITWIDTH-1:0]    a_q, a_d;
    logic signed [A_BITWIDTH-1:0]    b_q, b_d;
    logic signed [C_BITWIDTH-1:0]    c_q, c_d;

    logic signed [C_BITWIDTH-1:0]    clip_val;
    logic                            clip_hit;

    fc_sat_clip #(
        .IN_W  (OUT_BITWIDTH),
        .OUT_W (C_BITWIDTH)
    ) u_clip (
        .din  (bus.mac_mout),
        .dout (clip_val),
        .clip (clip_hit)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            sat_q     <= 1'b0;
            result_q  <= '0;
            rv_q      <= 1'b0;
            busy_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            mac_en_q  <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            sat_q     <= sat_d;
            result_q  <= result_d;
            rv_q      <= rv_d;
            busy_q    <= busy_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            mac_en_q  <= mac_en_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        sat_d     = sat_q;
        result_d  = result_q;
        rd_addr_d = rd_addr_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = bias;
                    idx_d   = '0;
                    sat_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                a_d     = bus.rd_data_a;
                b_d     = bus.rd_data_b;
                c_d     = acc_q;
                state_d = S_ISSUE;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.mac_done) begin
                    acc_d = clip_val;
                    if (clip_hit) begin
                        sat_d = 1'b1;
                    end
                    // The final sum leaves at full MAC width; only the feedback path is clipped.
                    if (idx_q == LAST_IDX) begin
                        result_d = bus.mac_mout;
                        state_d  = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the state being entered so they line up with it.
        busy_d   = (state_d != S_IDLE);
        rd_en_d  = (state_d == S_FETCH);
        mac_en_d = (state_d == S_ISSUE);
        rv_d     = (state_d == S_DONE);
        if (state_d == S_FETCH) begin
            rd_addr_d = idx_d;
        end
    end

    assign busy           = busy_q;
    assign result_valid   = rv_q;
    assign result         = result_q;
    assign sat            = sat_q;
    assign bus.rd_en      = rd_en_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.mac_en     = mac_en_q;
    assign bus.mac_data_a = a_q;
    assign bus.mac_data_b = b_q;
    assign bus.mac_data_c = c_q;

endmodule

// File: tb/tb_fc_mac_sequencer.sv
// Directed bench: three sequencers (VEC_LEN 4, 1, 2) each with a behavioural buffer and 4-cycle MAC.
// Cycle n counts from the cycle in which start is sampled (n = 0).
module tb_fc_mac_sequencer;

    logic                clk;
    logic                rstn;
    logic [2:0]          start_v;
    logic [2:0]          inj_done;
    logic signed [14:0]  bias_v [3];
    logic signed [7:0]   mem_a [3][4];
    logic signed [7:0]   mem_b [3][4];

    wire  [2:0]          rv_all;
    wire  [2:0]          busy_all;
    wire  [2:0]          sat_all;
    wire  signed [15:0]  res_all [3];

    int n_tests = 0;
    int n_fail  = 0;

    int addr_log [128];
    int rden_log [128];
    int men_log  [128];
    int busy_log [128];
    int a_log    [128];
    int b_log    [128];
    int c_log    [128];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int VL = (g == 0) ? 4 : ((g == 1) ? 1 : 2);
        localparam int AW = (VL > 1) ? $clog2(VL) : 1;

        fc_mac_sequencer_if #(
            .A_BITWIDTH(8), .OUT_BITWIDTH(16), .C_BITWIDTH(15), .ADDR_BITWIDTH(AW)
        ) bus ();

        logic               busy, rv, s;
        logic signed [15:0] res;
        logic        [2:0]  cnt;
        logic signed [15:0] mout;

        fc_mac_sequencer #(
            .A_BITWIDTH(8), .OUT_BITWIDTH(16), .C_BITWIDTH(15), .VEC_LEN(VL), .ADDR_BITWIDTH(AW)
        ) dut (
            .clk          (clk),
            .rstn         (rstn),
            .start        (start_v[g]),
            .bias         (bias_v[g]),
            .busy         (busy),
            .result_valid (rv),
            .result       (res),
            .sat          (s),
            .bus          (bus.master)
        );

        always @(posedge clk) begin
            if (bus.rd_en) begin
                bus.rd_data_a <= mem_a[g][bus.rd_addr];
                bus.rd_data_b <= mem_b[g][bus.rd_addr];
            end
        end

        // MAC answers in the 4th cycle after sampling mac_en.
        always @(posedge clk) begin
            if (!rstn) begin
                cnt <= 3'd0;
            end else if (cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end else if (bus.mac_en) begin
                cnt  <= 3'd4;
                mout <= 16'(32'(bus.mac_data_a) * 32'(bus.mac_data_b) + 32'(bus.mac_data_c));
            end
        end

        assign bus.mac_done = (cnt == 3'd1) || inj_done[g];
        assign bus.mac_mout = mout;
        assign rv_all[g]    = rv;
        assign busy_all[g]  = busy;
        assign sat_all[g]   = s;
        assign res_all[g]   = res;
    end

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"},   inst[0].busy, 0);
        check({tag, "_rv"},     inst[0].rv, 0);
        check({tag, "_result"}, inst[0].res, 0);
        check({tag, "_sat"},    inst[0].s, 0);
        check({tag, "_rd_en"},  inst[0].bus.rd_en, 0);
        check({tag, "_rdaddr"}, inst[0].bus.rd_addr, 0);
        check({tag, "_mac_en"}, inst[0].bus.mac_en, 0);
        check({tag, "_mac_a"},  inst[0].bus.mac_data_a, 0);
        check({tag, "_mac_c"},  inst[0].bus.mac_data_c, 0);
    endtask

    // Called at a negedge; start is sampled at the following posedge (cycle 0).
    task automatic run_job(input int id, input logic signed [14:0] bv, input int hold_n,
                           input int inj_at, input int rst_at, input int max_n,
                           input bit full, output int rv_cyc);
        for (int i = 0; i < 128; i++) begin
            addr_log[i] = 0; rden_log[i] = 0; men_log[i] = 0; busy_log[i] = 0;
            a_log[i] = 0; b_log[i] = 0; c_log[i] = 0;
        end
        bias_v[id]  = bv;
        start_v[id] = 1'b1;
        rv_cyc      = -1;
        for (int n = 1; n <= max_n; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n >= hold_n) start_v[id] = 1'b0;
            if (n < 128) begin
                addr_log[n] = int'(inst[0].bus.rd_addr);
                rden_log[n] = int'(inst[0].bus.rd_en);
                men_log[n]  = int'(inst[0].bus.mac_en);
                busy_log[n] = int'(inst[0].busy);
                a_log[n]    = int'(inst[0].bus.mac_data_a);
                b_log[n]    = int'(inst[0].bus.mac_data_b);
                c_log[n]    = int'(inst[0].bus.mac_data_c);
            end
            inj_done[id] = (n == inj_at);
            if (n == rst_at) rstn = 1'b0;
            if (n == rst_at + 1) begin
                check_reset_state("midrst");
                rstn = 1'b1;
            end
            if (rv_all[id] && rv_cyc < 0) rv_cyc = n;
            if (rv_cyc >= 0 && !full) break;
        end
    endtask

    initial begin
        int rc, cnt, adj, first_fetch;

        mem_a[0] = '{8'sd1, 8'sd3, -8'sd5, 8'sd7};
        mem_b[0] = '{8'sd2, 8'sd4, 8'sd6, -8'sd8};
        mem_a[1] = '{-8'sd128, 8'sd0, 8'sd0, 8'sd0};
        mem_b[1] = '{-8'sd128, 8'sd0, 8'sd0, 8'sd0};
        mem_a[2] = '{8'sd127, 8'sd0, 8'sd0, 8'sd0};
        mem_b[2] = '{8'sd127, 8'sd0, 8'sd0, 8'sd0};
        for (int i = 0; i < 3; i++) bias_v[i] = '0;
        start_v  = '0;
        inj_done = '0;
        rstn     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rstn = 1'b1;
        @(negedge clk);

        // VEC_LEN=4 golden dot product
        run_job(0, 15'sd10, 1, -10, -10, 200, 1'b0, rc);
        check("v4_result", res_all[0], -62);
        check("v4_rv_cycle", rc, 29);
        check("v4_sat", sat_all[0], 0);
        check("v4_busy_c1", busy_log[1], 1);
        check("v4_rdaddr_last", addr_log[22], 3);
        check("v4_mac_a_e3", a_log[24], 7);
        check("v4_mac_b_e3", b_log[24], -8);
        check("v4_mac_c_e3", c_log[24], -6);
        cnt = 0;
        for (int i = 1; i <= 29; i++) cnt += men_log[i];
        check("v4_mac_en_count", cnt, 4);
        @(posedge clk);
        @(negedge clk);
        check("v4_busy_after", busy_all[0], 0);
        check("v4_rv_pulse", rv_all[0], 0);
        check("v4_result_held", res_all[0], -62);

        // VEC_LEN=1 single pass
        run_job(1, -15'sd1, 1, -10, -10, 200, 1'b0, rc);
        check("v1_result", res_all[1], 16383);
        check("v1_rv_cycle", rc, 8);
        check("v1_sat", sat_all[1], 0);
        @(negedge clk);

        // VEC_LEN=2 with feedback clamp
        run_job(2, 15'sd16383, 1, -10, -10, 200, 1'b0, rc);
        check("v2_result", res_all[2], 16383);
        check("v2_rv_cycle", rc, 15);
        check("v2_sat", sat_all[2], 1);
        @(negedge clk);

        // start held high across a job boundary
        run_job(0, 15'sd10, 32, -10, -10, 40, 1'b1, rc);
        check("hold_rv_cycle", rc, 29);
        cnt = 0;
        adj = 0;
        first_fetch = -1;
        for (int i = 1; i <= 29; i++) cnt += men_log[i];
        for (int i = 2; i <= 40; i++) if (men_log[i] != 0 && men_log[i-1] != 0) adj++;
        for (int i = 30; i <= 40; i++) if (rden_log[i] != 0 && first_fetch < 0) first_fetch = i;
        check("hold_mac_en_count", cnt, 4);
        check("hold_mac_en_adjacent", adj, 0);
        check("hold_next_fetch", first_fetch, 31);
        rc = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (rv_all[0]) begin
                rc = k;
                break;
            end
        end
        check("hold_job2_rv", rc, 19);
        check("hold_job2_result", res_all[0], -62);
        @(negedge clk);

        // reset during the 3rd WAIT of element 2 aborts the job
        run_job(0, 15'sd10, 1, -10, 20, 45, 1'b0, rc);
        check("midrst_no_rv", rc, -1);
        check("midrst_busy_end", busy_all[0], 0);
        run_job(0, 15'sd10, 1, -10, -10, 200, 1'b0, rc);
        check("postrst_result", res_all[0], -62);
        check("postrst_rv_cycle", rc, 29);
        @(negedge clk);

        // spurious mac_done while in FETCH of element 1
        run_job(0, 15'sd10, 1, 8, -10, 200, 1'b0, rc);
        check("spur_rdaddr", addr_log[8], 1);
        check("spur_acc_fed", c_log[10], 12);
        check("spur_result", res_all[0], -62);
        check("spur_rv_cycle", rc, 29);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fc_mac_sequencer.md
# fc_mac_sequencer

Initiator for the fully-connected layer's multiply-accumulate unit. It walks an operand buffer of `VEC_LEN` weight/activation pairs and issues one `en` pulse per pair to the MAC. Each partial sum is fed back as the next addend, and the finished dot product plus bias is presented with a one-cycle valid pulse. It sits between the FC operand buffer and the MAC, on the opposite side of the MAC's `en`/`done` handshake.

## Interface
- `A_BITWIDTH`, 8, activation/weight width (signed)
- `OUT_BITWIDTH`, 16, MAC output width (signed)
- `C_BITWIDTH`, `OUT_BITWIDTH-1`, MAC addend width (signed)
- `VEC_LEN`, 16, pairs per dot product (≥1)
- `ADDR_BITWIDTH`, `$clog2(VEC_LEN)` (min 1), buffer address width
- `clk`  in  1  single clock, rising edge
- `rstn`  in  1  reset, synchronous, active-low
- `start`  in  1  begin a dot product; sampled only in IDLE
- `bias`  in  C_BITWIDTH  initial addend, latched with `start`
- `busy`  out  1  high whenever state ≠ IDLE
- `rd_en`  out  1  buffer read strobe
- `rd_addr`  out  ADDR_BITWIDTH  buffer address
- `rd_data_a`, `rd_data_b`  in  A_BITWIDTH each  buffer data, valid the cycle after `rd_en`
- `mac_en`  out  1  MAC request, one-cycle pulse
- `mac_data_a`, `mac_data_b`  out  A_BITWIDTH each  MAC operands
- `mac_data_c`  out  C_BITWIDTH  MAC addend
- `mac_done`  in  1  MAC completion pulse; `mac_mout` valid in the same cycle
- `mac_mout`  in  OUT_BITWIDTH  MAC result
- `result_valid`  out  1  one-cycle pulse
- `result`  out  OUT_BITWIDTH  final dot product, held until the next `result_valid`
- `sat`  out  1  sticky per job: an intermediate sum was clipped during feedback

## Operation
- States: IDLE, FETCH, LOAD, ISSUE, WAIT, DONE.
- **IDLE:** on `start`, latch `acc <= bias`, `idx <= 0`, clear `sat`, go to FETCH.
- **FETCH:** `rd_en=1`, `rd_addr=idx` for this cycle only; go to LOAD.
- **LOAD:** register `mac_data_a <= rd_data_a`, `mac_data_b <= rd_data_b`, `mac_data_c <= acc`; go to ISSUE.
- **ISSUE:** `mac_en=1` for exactly this cycle; operands are held stable from here until `mac_done`; go to WAIT.
- **WAIT:** hold until `mac_done`. On `mac_done`:
  - Saturate `mac_mout` to the signed C_BITWIDTH range: above 2^(C-1)-1 clamps to max, below -2^(C-1) clamps to min. On any clamp, set `sat`.
  - Write the saturated value to `acc`.
  - If `idx == VEC_LEN-1`: register `result <= mac_mout` unsaturated at full width, go to DONE.
  - Otherwise: `idx <= idx+1`, go to FETCH.
- **DONE:** `result_valid=1`; go to IDLE.
- Boundary rules:
  - `start` is ignored while busy.
  - `start` in the DONE cycle is ignored; it is accepted the following IDLE cycle.
  - `mac_done` outside WAIT is ignored.
  - `VEC_LEN=1` gives a single MAC pass.
  - `rd_addr` never exceeds `VEC_LEN-1`; there is no wrap-around within a job.
- Reset:
  - The first edge with `rstn=0` forces IDLE and clears `acc`, `idx`, `sat` and every output (`result`, `mac_data_*`, `rd_addr` all 0).
  - Reset mid-job aborts with no `result_valid`.
  - The MAC shares `rstn`, so both ends return to idle together.

## Timing
- All outputs are registered.
- Per element: FETCH, LOAD and ISSUE take 1 cycle each, then WAIT.
- MAC latency: `mac_en` sampled at the end of ISSUE; `mac_done` arrives 4 cycles later, in the 4th WAIT cycle. That gives 7 cycles per element.
- With `start` sampled at cycle 0:
  - element k's `mac_done` falls in cycle 7k+7;
  - `result_valid` is in cycle 7·VEC_LEN+1 (113 for `VEC_LEN=16`);
  - `busy` is high in cycles 1 through 7·VEC_LEN+1;
  - back-to-back jobs start every 7·VEC_LEN+2 cycles.
- `mac_en` is never high in two consecutive cycles, and never while the MAC is still busy; this guarantees that no MAC request is dropped.

## Structure
- Shared package `fc_pkg`:
  - state encoding localparams;
  - default widths (8/16/15);
  - the signed saturation bounds expressed as functions of C_BITWIDTH.
- Sub-module `fc_sat_clip`: combinational OUT_BITWIDTH→C_BITWIDTH signed saturator with a clip flag. It is reused by later FC output stages.
- Remaining logic (FSM, index counter, accumulator, output registers) lives in one file.

## Test plan
- `VEC_LEN=4`, bias=10, pairs (1,2),(3,4),(-5,6),(7,-8) with a behavioural MAC:
  - `result` = 10+2+12−30−56 = −62;
  - `result_valid` in cycle 29;
  - `sat`=0.
- `VEC_LEN=1`, bias=−1, pair (−128,−128): `result` = 16383 (0x3FFF), `result_valid` in cycle 8, no clipping.
- `VEC_LEN=2`, bias=16383, pairs (127,127),(0,0):
  - 1st `mac_mout` = 32512 clamps to 16383 and sets `sat`;
  - `result` = 16383;
  - `sat`=1.
- `start` held high throughout a `VEC_LEN=4` job:
  - exactly one `mac_en` per element;
  - next job's FETCH in cycle 31;
  - `mac_en` is never high in adjacent cycles.
- `rstn` low for one edge during the 3rd WAIT of element 2:
  - next cycle IDLE, all outputs 0, no `result_valid`;
  - a fresh job then completes correctly.
- Spurious `mac_done` injected during FETCH: ignored; `idx` and `acc` unchanged; `result` matches the golden value.
